// File: rtl/spio_hss_multiplexer_prbs_checker.sv
// Receive-side checker for the spiNNlink 16-bit PRBS test stream: aligns to the
// sequence start, compares each valid word and keeps lock status plus counters.
module spio_hss_multiplexer_prbs_checker #(
  parameter int LOCK_WORDS = 4,
  parameter int LOSS_WORDS = 8,
  parameter int CNT_BITS   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                vld_in,
  input  logic [15:0]         data_in,
  output logic                locked,
  output logic                err,
  output logic [15:0]         err_bits,
  output logic [CNT_BITS-1:0] err_cnt,
  output logic [CNT_BITS-1:0] word_cnt
);

  localparam logic [15:0] SEED      = 16'hffff;
  localparam logic [15:0] SYNC_WORD = 16'h768d;
  localparam int MATCH_W = $clog2(LOCK_WORDS + 1);
  localparam int LOSS_W  = $clog2(LOSS_WORDS + 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(LOCK_WORDS);
  localparam logic [LOSS_W-1:0]  LOSS_ONE  = LOSS_W'(1);
  localparam logic [LOSS_W-1:0]  LOSS_TGT  = LOSS_W'(LOSS_WORDS);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t              r_state;
  logic [15:0]         r_gen;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [LOSS_W-1:0]   r_loss_cnt;
  logic                r_locked;
  logic                r_err;
  logic [15:0]         r_err_bits;
  logic [CNT_BITS-1:0] r_err_cnt;
  logic [CNT_BITS-1:0] r_word_cnt;

  state_t              w_state_next;
  logic [15:0]         w_gen_next;
  logic [MATCH_W-1:0]  w_match_cnt_next;
  logic [LOSS_W-1:0]   w_loss_cnt_next;
  logic                w_err_next;
  logic [15:0]         w_err_bits_next;
  logic [CNT_BITS-1:0] w_err_cnt_next;
  logic [CNT_BITS-1:0] w_word_cnt_next;

  logic [15:0]         w_gen_adv;
  logic [15:0]         w_expected;
  logic [15:0]         w_diff;
  logic                w_match;
  logic [MATCH_W-1:0]  w_match_inc;
  logic [LOSS_W-1:0]   w_loss_inc;
  logic [CNT_BITS-1:0] w_err_cnt_inc;
  logic [CNT_BITS-1:0] w_word_cnt_inc;

  // Sixteen serial steps of b[n] = b[n-1]^b[n-3]^b[n-12]^b[n-16] (x16+x15+x13+x4+1);
  // the register holds the raw LFSR bits, oldest bit in bit 0.
  always_comb begin : gen_advance
    logic [31:0] v_ext;
    v_ext = {16'h0000, r_gen};
    for (int j = 0; j < 16; j++) begin
      v_ext[16+j] = v_ext[15+j] ^ v_ext[13+j] ^ v_ext[4+j] ^ v_ext[j];
    end
    w_gen_adv = v_ext[31:16];
  end

  // The transmitted word is the inverted LFSR output, which makes the seed
  // 16'hffff produce 16'h768d as the first word.
  assign w_expected     = ~w_gen_adv;
  assign w_diff         = data_in ^ w_expected;
  assign w_match        = (w_diff == 16'h0000);
  assign w_match_inc    = r_match_cnt + MATCH_ONE;
  assign w_loss_inc     = r_loss_cnt + LOSS_ONE;
  assign w_err_cnt_inc  = (&r_err_cnt)  ? r_err_cnt  : r_err_cnt  + CNT_ONE;
  assign w_word_cnt_inc = (&r_word_cnt) ? r_word_cnt : r_word_cnt + CNT_ONE;

  always_comb begin
    w_state_next     = r_state;
    w_gen_next       = r_gen;
    w_match_cnt_next = r_match_cnt;
    w_loss_cnt_next  = r_loss_cnt;
    w_err_next       = 1'b0;
    w_err_bits_next  = r_err_bits;
    w_err_cnt_next   = r_err_cnt;
    w_word_cnt_next  = r_word_cnt;

    if (vld_in) begin
      case (r_state)
        S_HUNT: begin
          if (data_in == SYNC_WORD) begin
            w_gen_next       = w_gen_adv;
            w_match_cnt_next = MATCH_ONE;
            w_loss_cnt_next  = '0;
            w_state_next     = (MATCH_ONE == MATCH_TGT) ? S_LOCKED : S_VERIFY;
          end
        end
        S_VERIFY: begin
          w_err_bits_next = w_diff;
          if (w_match) begin
            w_gen_next       = w_gen_adv;
            w_match_cnt_next = w_match_inc;
            if (w_match_inc == MATCH_TGT) begin
              w_state_next    = S_LOCKED;
              w_loss_cnt_next = '0;
            end
          end else begin
            w_state_next     = S_HUNT;
            w_gen_next       = SEED;
            w_match_cnt_next = '0;
          end
        end
        S_LOCKED: begin
          w_err_bits_next = w_diff;
          w_gen_next      = w_gen_adv;
          w_word_cnt_next = w_word_cnt_inc;
          if (w_match) begin
            w_loss_cnt_next = '0;
          end else begin
            w_err_next      = 1'b1;
            w_err_cnt_next  = w_err_cnt_inc;
            w_loss_cnt_next = w_loss_inc;
            if (w_loss_inc == LOSS_TGT) begin
              w_state_next     = S_HUNT;
              w_gen_next       = SEED;
              w_loss_cnt_next  = '0;
              w_match_cnt_next = '0;
            end
          end
        end
        default: begin
          w_state_next     = S_HUNT;
          w_gen_next       = SEED;
          w_match_cnt_next = '0;
          w_loss_cnt_next  = '0;
        end
      endcase
    end

    // clr wins over a word counted in the same cycle.
    if (clr) begin
      w_err_cnt_next  = '0;
      w_word_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_gen       <= SEED;
      r_match_cnt <= '0;
      r_loss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_bits  <= 16'h0000;
      r_err_cnt   <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_gen       <= w_gen_next;
      r_match_cnt <= w_match_cnt_next;
      r_loss_cnt  <= w_loss_cnt_next;
      r_locked    <= (w_state_next == S_LOCKED);
      r_err       <= w_err_next;
      r_err_bits  <= w_err_bits_next;
      r_err_cnt   <= w_err_cnt_next;
      r_word_cnt  <= w_word_cnt_next;
    end
  end

  assign locked   = r_locked;
  assign err      = r_err;
  assign err_bits = r_err_bits;
  assign err_cnt  = r_err_cnt;
  assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_spio_hss_multiplexer_prbs_checker.sv
// Bench for the PRBS checker: table vectors, directed corner sequences and a
// randomized stream checked against a word-indexed reference model.
module tb_spio_hss_multiplexer_prbs_checker;

  localparam int NWORDS   = 8192;
  localparam int M_HUNT   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;
  localparam int LOCK_N   = 4;
  localparam int LOSS_N   = 8;

  logic        clk = 1'b0;
  logic        rst, clr, vld_in;
  logic [15:0] data_in;
  logic        locked, err, locked4, err4;
  logic [15:0] err_bits, err_bits4;
  logic [31:0] err_cnt, word_cnt;
  logic [3:0]  err_cnt4, word_cnt4;

  always #5 clk = ~clk;

  spio_hss_multiplexer_prbs_checker dut (
    .clk(clk), .rst(rst), .clr(clr), .vld_in(vld_in), .data_in(data_in),
    .locked(locked), .err(err), .err_bits(err_bits),
    .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  spio_hss_multiplexer_prbs_checker #(.CNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .vld_in(vld_in), .data_in(data_in),
    .locked(locked4), .err(err4), .err_bits(err_bits4),
    .err_cnt(err_cnt4), .word_cnt(word_cnt4)
  );

  // Reference PRBS: serial bit sequence, word k = inverted bits 16k..16k+15 after the seed.
  bit          bits_arr [0:16*NWORDS+15];
  logic [15:0] words [0:NWORDS-1];

  int          m_state, m_pos, m_match, m_loss;
  longint      m_errc, m_wordc;
  logic        m_err;
  logic [15:0] m_bits;

  int n_checks = 0;
  int n_errors = 0;
  bit verbose  = 1'b1;

  typedef struct {
    logic        vld;
    logic [15:0] data;
    logic        clr;
    logic        e_locked;
    logic        e_err;
    logic [15:0] e_bits;
    int          e_errc;
    int          e_wordc;
  } vec_t;

  vec_t tbl [0:9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_update(input logic r, input logic v, input logic [15:0] d, input logic c);
    logic [15:0] e;
    if (r) begin
      m_state = M_HUNT; m_pos = 0; m_match = 0; m_loss = 0;
      m_err = 1'b0; m_bits = 16'h0000; m_errc = 0; m_wordc = 0;
    end else begin
      m_err = 1'b0;
      if (v) begin
        if (m_state == M_HUNT) begin
          if (d == 16'h768d) begin
            m_pos = 1; m_match = 1; m_state = M_VERIFY;
          end
        end else begin
          e = words[m_pos];
          m_pos++;
          m_bits = d ^ e;
          if (m_state == M_VERIFY) begin
            if (d == e) begin
              m_match++;
              if (m_match == LOCK_N) begin m_state = M_LOCKED; m_loss = 0; end
            end else begin
              m_state = M_HUNT; m_pos = 0; m_match = 0;
            end
          end else begin
            m_wordc++;
            if (d != e) begin
              m_err = 1'b1; m_errc++; m_loss++;
              if (m_loss == LOSS_N) begin m_state = M_HUNT; m_pos = 0; m_loss = 0; m_match = 0; end
            end else begin
              m_loss = 0;
            end
          end
        end
      end
      if (c) begin m_errc = 0; m_wordc = 0; end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] d, input logic c);
    rst = r; vld_in = v; data_in = d; clr = c;
    @(posedge clk);
    model_update(r, v, d, c);
    #1;
    if (verbose)
      $display("txn t=%0t rst=%b vld=%b clr=%b data=%h -> locked=%b err=%b bits=%h errc=%0d wordc=%0d",
               $time, r, v, c, d, locked, err, err_bits, err_cnt, word_cnt);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " locked"},    32'(locked),    32'(m_state == M_LOCKED));
    chk({tag, " err"},       32'(err),       32'(m_err));
    chk({tag, " err_bits"},  32'(err_bits),  32'(m_bits));
    chk({tag, " err_cnt"},   err_cnt,        32'(sat(m_errc, 64'hffff_ffff)));
    chk({tag, " word_cnt"},  word_cnt,       32'(sat(m_wordc, 64'hffff_ffff)));
    chk({tag, " locked4"},   32'(locked4),   32'(m_state == M_LOCKED));
    chk({tag, " err_cnt4"},  32'(err_cnt4),  32'(sat(m_errc, 15)));
    chk({tag, " word_cnt4"}, 32'(word_cnt4), 32'(sat(m_wordc, 15)));
  endtask

  task automatic feed(input int start, input int count, input int idle_pct,
                      input logic [15:0] mask, input string tag);
    int k = 0;
    while (k < count) begin
      if (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
        step(1'b0, 1'b0, 16'($urandom), 1'b0);
      end else begin
        step(1'b0, 1'b1, words[start+k] ^ mask, 1'b0);
        k++;
      end
      check_model(tag);
    end
  endtask

  initial begin
    int p;
    int tx_pos;
    logic v, c, r;
    logic [15:0] d;

    for (int i = 0; i < 16; i++) bits_arr[i] = 1'b1;
    for (int n = 16; n < 16*NWORDS+16; n++)
      bits_arr[n] = bits_arr[n-1] ^ bits_arr[n-3] ^ bits_arr[n-12] ^ bits_arr[n-16];
    for (int k = 0; k < NWORDS; k++)
      for (int j = 0; j < 16; j++)
        words[k][j] = ~bits_arr[16 + 16*k + j];

    tbl[0] = '{1'b1, words[0],           1'b0, 1'b0, 1'b0, 16'h0000, 0, 0};
    tbl[1] = '{1'b1, words[1],           1'b0, 1'b0, 1'b0, 16'h0000, 0, 0};
    tbl[2] = '{1'b1, words[2],           1'b0, 1'b0, 1'b0, 16'h0000, 0, 0};
    tbl[3] = '{1'b1, words[3],           1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[4] = '{1'b0, 16'h768d,           1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[5] = '{1'b1, words[4],           1'b0, 1'b1, 1'b0, 16'h0000, 0, 1};
    tbl[6] = '{1'b1, words[5] ^ 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0001, 1, 2};
    tbl[7] = '{1'b1, words[6] ^ 16'h8000, 1'b1, 1'b1, 1'b1, 16'h8000, 0, 0};
    tbl[8] = '{1'b0, 16'h1234,           1'b0, 1'b1, 1'b0, 16'h8000, 0, 0};
    tbl[9] = '{1'b1, words[7],           1'b0, 1'b1, 1'b0, 16'h0000, 0, 1};

    // Reset state
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model("reset");

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].vld, tbl[i].data, tbl[i].clr);
      chk($sformatf("tbl%0d locked", i),   32'(locked),   32'(tbl[i].e_locked));
      chk($sformatf("tbl%0d err", i),      32'(err),      32'(tbl[i].e_err));
      chk($sformatf("tbl%0d err_bits", i), 32'(err_bits), 32'(tbl[i].e_bits));
      chk($sformatf("tbl%0d err_cnt", i),  err_cnt,       32'(tbl[i].e_errc));
      chk($sformatf("tbl%0d word_cnt", i), word_cnt,      32'(tbl[i].e_wordc));
    end

    // Reset while locked
    step(1'b1, 1'b1, words[8], 1'b0);
    chk("midrst locked",   32'(locked),   32'h0);
    chk("midrst err",      32'(err),      32'h0);
    chk("midrst err_bits", 32'(err_bits), 32'h0);
    chk("midrst err_cnt",  err_cnt,       32'h0);
    chk("midrst word_cnt", word_cnt,      32'h0);

    // Mismatch on the third word in VERIFY: back to HUNT, never locks
    feed(0, 2, 0, 16'h0000, "vfy");
    step(1'b0, 1'b1, words[2] ^ 16'h0040, 1'b0);
    check_model("vfy_mis");
    chk("vfy_mis err_bits", 32'(err_bits), 32'h0040);
    step(1'b0, 1'b1, words[3], 1'b0);
    check_model("vfy_after");
    chk("vfy_after locked", 32'(locked), 32'h0);
    chk("vfy_after err_cnt", err_cnt, 32'h0);

    // Clean lock and 100 words
    feed(0, 4, 0, 16'h0000, "lock");
    chk("lock locked", 32'(locked), 32'h1);
    feed(4, 100, 0, 16'h0000, "run100");
    chk("run100 word_cnt", word_cnt, 32'd100);
    chk("run100 err_cnt",  err_cnt,  32'd0);

    // Eight consecutive corrupted words lose lock; restart relocks
    feed(104, 8, 0, 16'h0a50, "loss");
    chk("loss err_cnt", err_cnt, 32'd8);
    chk("loss locked",  32'(locked), 32'h0);
    feed(0, 3, 0, 16'h0000, "relock");
    chk("relock3 locked", 32'(locked), 32'h0);
    feed(3, 1, 0, 16'h0000, "relock");
    chk("relock4 locked", 32'(locked), 32'h1);

    // clr on the same cycle as a counted mismatch
    step(1'b0, 1'b1, words[4] ^ 16'h0001, 1'b1);
    check_model("clr_mis");
    chk("clr_mis err_cnt", err_cnt, 32'd0);
    chk("clr_mis err",     32'(err), 32'h1);

    // Gapped stream: same counts as gapless
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    feed(0, 4, 40, 16'h0000, "gap_lock");
    feed(4, 100, 40, 16'h0000, "gap_run");
    chk("gap word_cnt", word_cnt, 32'd100);
    chk("gap err_cnt",  err_cnt,  32'd0);

    // Saturation of the 4-bit instance with alternating errors
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    feed(0, 4, 0, 16'h0000, "sat_lock");
    p = 4;
    for (int i = 0; i < 20; i++) begin
      feed(p, 1, 0, 16'h0100, "sat_bad");
      feed(p + 1, 1, 0, 16'h0000, "sat_good");
      p += 2;
    end
    chk("sat err_cnt4",  32'(err_cnt4),  32'hf);
    chk("sat err_cnt",   err_cnt,        32'd20);
    chk("sat word_cnt4", 32'(word_cnt4), 32'hf);
    chk("sat locked",    32'(locked),    32'h1);

    // Randomized stream
    verbose = 1'b0;
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    tx_pos = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v = ($urandom_range(0, 99) < 70);
      d = 16'($urandom);
      if (v) begin
        if (m_state == M_HUNT && $urandom_range(0, 3) == 0) begin
          d = 16'($urandom);
        end else begin
          if (m_state == M_HUNT || tx_pos >= NWORDS - 1) tx_pos = 0;
          d = words[tx_pos];
          tx_pos++;
          if ($urandom_range(0, 99) < 4) d = d ^ 16'(1 << $urandom_range(0, 15));
        end
      end
      c = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 999) == 0);
      step(r, v, d, c);
      check_model("rand");
    end
    $display("random phase done: final word_cnt=%0d err_cnt=%0d", word_cnt, err_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spio_hss_multiplexer_prbs_checker.md
Name: spio_hss_multiplexer_prbs_checker

Overview:
Receive-side checker for the spiNNlink 16-bit PRBS test stream. It aligns to the start of the pseudo-random word sequence, compares every valid received word against a locally generated expected word, and reports lock status, per-word error pulses and saturating error and word counters. It sits after the HSS receive path and is used for link bring-up and bit-error-rate measurement.

Parameters:
LOCK_WORDS, 4, consecutive matching words, counted from the seed word inclusive, needed to enter LOCKED.
LOSS_WORDS, 8, consecutive mismatching words in LOCKED that force a return to HUNT.
CNT_BITS, 32, width of err_cnt and word_cnt.

Ports:
clk  input  1  clock
rst  input  1  reset
clr  input  1  clear counters; single-cycle pulse
vld_in  input  1  data_in holds a valid received word this cycle
data_in  input  16  received PRBS word
locked  output  1  checker is in LOCKED
err  output  1  one-cycle pulse: the word just checked mismatched while LOCKED
err_bits  output  16  XOR of received and expected word for the last checked word
err_cnt  output  CNT_BITS  mismatching words while LOCKED, saturating
word_cnt  output  CNT_BITS  words checked while LOCKED, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is named clk and reset port is named rst.
- Expected-word generator:
  - 16-bit word-parallel LFSR, polynomial x16+x15+x13+x4+1, advancing 16 bit-steps per word.
  - Seed is 16'hffff.
  - The first word after the seed is 16'h768d. The generator is bit-identical to the link PRBS transmitter.
  - In HUNT the generator is held at the seed.
- States: HUNT, VERIFY, LOCKED.
  - HUNT: on vld_in with data_in==16'h768d, advance the generator and go to VERIFY with the match count set to 1. Any other word is ignored.
  - VERIFY:
    - On each vld_in, compare data_in with the expected word and advance the generator regardless of the result.
    - A match increments the match count; reaching LOCK_WORDS moves to LOCKED.
    - Any mismatch returns to HUNT and reseeds the generator.
    - Mismatches in VERIFY do not count as errors.
  - LOCKED:
    - On each vld_in, compare, advance the generator and increment word_cnt.
    - A mismatch pulses err, increments err_cnt and increments the loss counter.
    - A match clears the loss counter.
    - When the loss counter reaches LOSS_WORDS, go to HUNT and reseed. The word that triggers the transition is still counted.
- Cycles without vld_in: no state change, no generator advance, no count change, err=0.
- Latency: all outputs are registered. err, err_bits and the counters update on the clock edge that samples vld_in, so they are visible the following cycle. locked rises on the edge that accepts the LOCK_WORDS-th matching word.
- err_bits updates only on vld_in cycles in VERIFY or LOCKED and holds otherwise.
- Counters saturate at all-ones and never wrap.
- clr:
  - Zeroes err_cnt and word_cnt without affecting state or the generator.
  - If clr coincides with a counted word, the counter result is 0 for err_cnt and 0 for word_cnt. clr has priority and that word is not counted.
- Reset mid-operation: returns to HUNT and reseeds.
- Reset values: locked=0, err=0, err_bits=16'h0000, err_cnt=0, word_cnt=0, state HUNT, match and loss counters 0, generator 16'hffff.
- A received 16'h768d in LOCKED has no special meaning and is compared normally.

Test Plan:
- Reset, then feed the reference PRBS stream starting at 16'h768d, one word per cycle → locked=1 after the 4th word; err stays 0. After 100 more words: word_cnt=100, err_cnt=0.
- Locked stream with word 10 XORed by 16'h0001 → one err pulse, err_bits=16'h0001, err_cnt=1, locked remains 1.
- Locked, then 8 consecutive corrupted words → err_cnt=8, locked=0 after the 8th. A restarted stream beginning 16'h768d relocks after 4 words.
- Stream with vld_in toggled pseudo-randomly → same counts as the gapless case; no errors from idle cycles.
- Mismatch on the 3rd word in VERIFY → back to HUNT, err_cnt=0, locked never asserts. Also: clr asserted on the same cycle as a counted mismatch → err_cnt=0 next cycle.
- Force err_cnt near all-ones (CNT_BITS=4) and keep mismatching while locked → err_cnt stays 4'hf. Also: rst mid-lock → all outputs return to reset values the next cycle.
